// File: rtl/max_pooling_2x2_if.sv
// max_pooling_2x2_if -- pixel-in / pooled-out bus for the 2x2 max-pool stage.
//   fire     pixel valid; data_in/row are consumed on the edge when 1
//   data_in  pixel, unsigned DATA_W
//   row      0 = top row of a 2-row band, 1 = bottom row
//   data_out pooled max, registered, holds between results
//   done     1-cycle strobe marking a new data_out
// master = pixel producer, slave = pooling stage.
interface max_pooling_2x2_if #(
  parameter int DATA_W = 6
);
  logic              fire;
  logic              row;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;

  modport master (output fire, row, data_in, input  data_out, done);
  modport slave  (input  fire, row, data_in, output data_out, done);
endinterface

// File: rtl/max_pooling_2x2.sv
// max_pooling_2x2 -- streaming 2x2 / stride-2 max pooling.
// Pixels arrive in raster order, one row per pass. The top row of each band
// is reduced pairwise into a ROW_LEN/2 line buffer; during the bottom row
// each horizontal pair is merged with its buffered top-row max and emitted
// one clock after the odd-column pixel, flagged by a 1-cycle done.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (wins over fire)
//   bus   max_pooling_2x2_if.slave (fire, row, data_in -> data_out, done)
// Optional build macro MAXPOOL_ROW_RESYNC_EN: a change of row between two
// consumed pixels forces the new pixel to column 0, realigning short rows.
module max_pooling_2x2 #(
  parameter int DATA_W  = 6,
  parameter int ROW_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  max_pooling_2x2_if.slave     bus
);
  localparam int NBUF = ROW_LEN / 2;
  localparam int CW   = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
  localparam int IW   = (NBUF > 1) ? $clog2(NBUF) : 1;

  logic [CW-1:0]               r_col;
  logic [DATA_W-1:0]           r_hold;
  logic [NBUF-1:0][DATA_W-1:0] r_buf;
  logic [DATA_W-1:0]           r_dout;
  logic                        r_done;

  logic [CW-1:0]               w_col;      // column of the pixel on the bus
  logic [CW-1:0]               w_col_nxt;
  logic [IW-1:0]               w_idx;
  logic [DATA_W-1:0]           w_h;        // horizontal pair max
  logic [DATA_W-1:0]           w_top;      // buffered top-row max for this window
  logic [DATA_W-1:0]           w_win;      // full 2x2 window max

`ifdef MAXPOOL_ROW_RESYNC_EN
  logic r_prev_row;
  // A row transition means a new row has started, whatever the count says.
  assign w_col = (bus.row != r_prev_row) ? '0 : r_col;
`else
  assign w_col = r_col;
`endif

  assign w_col_nxt = (w_col == CW'(ROW_LEN - 1)) ? '0 : w_col + 1'b1;
  assign w_idx     = IW'(w_col >> 1);
  assign w_h       = (bus.data_in > r_hold) ? bus.data_in : r_hold;
  assign w_top     = r_buf[w_idx];
  assign w_win     = (w_h > w_top) ? w_h : w_top;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_hold <= '0;
      r_buf  <= '0;
      r_dout <= '0;
      r_done <= 1'b0;
`ifdef MAXPOOL_ROW_RESYNC_EN
      r_prev_row <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.fire) begin
        r_col <= w_col_nxt;
`ifdef MAXPOOL_ROW_RESYNC_EN
        r_prev_row <= bus.row;
`endif
        if (!w_col[0]) begin
          r_hold <= bus.data_in;
        end else if (!bus.row) begin
          r_buf[w_idx] <= w_h;
        end else begin
          r_dout <= w_win;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out = r_dout;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_max_pooling_2x2.sv
module tb_max_pooling_2x2;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  max_pooling_2x2_if #(.DATA_W(DW)) bus ();

  max_pooling_2x2 #(.DATA_W(DW), .ROW_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          fire;
    logic          row;
    logic [DW-1:0] din;
    logic          exp_done;
    logic [DW-1:0] exp_out;
  } vec_t;

  vec_t          vq[$];
  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] last   = '0;   // expected held data_out

  int bot1 [16] = '{21, 22, 23, 24, 25, 26, 27, 28, 9, 10, 1, 2, 3, 4, 5, 6};
  int out1 [8]  = '{22, 24, 26, 28, 10, 12, 14, 16};
`ifdef MAXPOOL_ROW_RESYNC_EN
  int outr [8]  = '{2, 4, 6, 8, 10, 12, 14, 41};
`else
  int outr [8]  = '{15, 2, 4, 6, 8, 10, 12, 40};
`endif

  task automatic add(input logic r, input logic f, input logic rw,
                     input logic [DW-1:0] d, input logic ed,
                     input logic [DW-1:0] eo);
    vec_t v;
    v.rst = r; v.fire = f; v.row = rw; v.din = d;
    v.exp_done = ed; v.exp_out = eo;
    vq.push_back(v);
  endtask

  // consumed pixel, no result expected
  task automatic px(input logic rw, input int d);
    add(1'b0, 1'b1, rw, DW'(d), 1'b0, last);
  endtask

  // consumed pixel that completes a window with result o
  task automatic pxo(input logic rw, input int d, input int o);
    last = DW'(o);
    add(1'b0, 1'b1, rw, DW'(d), 1'b1, last);
  endtask

  // bus idle; data/row set to junk that must be ignored
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, DW'(63), 1'b0, last);
  endtask

  // reset with fire asserted: reset must win
  task automatic rst_v();
    last = '0;
    add(1'b1, 1'b1, 1'b1, DW'(63), 1'b0, '0);
  endtask

  task automatic run(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      rst         = vq[i].rst;
      bus.fire    = vq[i].fire;
      bus.row     = vq[i].row;
      bus.data_in = vq[i].din;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done === vq[i].exp_done && bus.data_out === vq[i].exp_out)
        passes++;
      else
        $display("FAIL %s[%0d]: done=%b data_out=%0d, expected done=%b data_out=%0d",
                 name, i, bus.done, bus.data_out, vq[i].exp_done, vq[i].exp_out);
    end
    vq.delete();
    rst      = 1'b0;
    bus.fire = 1'b0;
  endtask

  initial begin
    bus.fire = 1'b0; bus.row = 1'b0; bus.data_in = '0;

    // reset, then 5 idle clocks
    add(1'b1, 1'b1, 1'b0, DW'(7), 1'b0, '0);
    add(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(5);
    run("reset_idle");

    // band 1
    for (int i = 1; i <= 16; i++) px(1'b0, i);
    for (int j = 0; j < 16; j++)
      if (j % 2 == 1) pxo(1'b1, bot1[j], out1[j/2]); else px(1'b1, bot1[j]);
    run("band1");

    // same band with a 3-clock stall after pixel 5 of the bottom row
    for (int i = 1; i <= 16; i++) px(1'b0, i);
    for (int j = 0; j < 16; j++) begin
      if (j == 5) idle(3);
      if (j % 2 == 1) pxo(1'b1, bot1[j], out1[j/2]); else px(1'b1, bot1[j]);
    end
    run("stall");

    // second bottom row reuses buffered top-row maxima 2,4,...,16
    for (int j = 0; j < 16; j++)
      if (j % 2 == 1) pxo(1'b1, 0, 2 * (j/2 + 1)); else px(1'b1, 0);
    run("rebottom");

    // reset after 7 pixels of a top row
    for (int i = 0; i < 7; i++) px(1'b0, 50 + i);
    rst_v();
    idle(1);
    run("mid_reset");

    // fresh band of 63s, column must restart at 0
    for (int i = 0; i < 16; i++) px(1'b0, 63);
    for (int j = 0; j < 16; j++)
      if (j % 2 == 1) pxo(1'b1, 63, 63); else px(1'b1, 63);
    run("band63");

    // short top row (15 pixels) followed by a full bottom row
    rst_v();
    for (int i = 1; i <= 15; i++) px(1'b0, i);
    for (int j = 0; j < 16; j++) begin
      int d;
      d = (j == 14) ? 40 : (j == 15) ? 41 : 0;
`ifdef MAXPOOL_ROW_RESYNC_EN
      if (j % 2 == 1) pxo(1'b1, d, outr[j/2]); else px(1'b1, d);
`else
      if (j % 2 == 0) pxo(1'b1, d, outr[j/2]); else px(1'b1, d);
`endif
    end
    run("short_row");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
